// File: rtl/switch_allocator_pkg.sv
// Shared defaults and per-output FSM state encoding for the switch allocator.
package switch_allocator_pkg;

    localparam int unsigned PORTS_DEF     = 5;
    localparam int unsigned CHNL_BITS_DEF = 3;
    localparam int unsigned ADDR_BITS_DEF = 3;
    localparam int unsigned FLIT_BITS_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } out_state_e;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping
// to the lowest requester below ptr. Grant is one-hot (or zero if no request).
module rr_arbiter #(
    parameter int unsigned N  = 5,
    parameter int unsigned PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic [N-1:0] mask;
    logic [N-1:0] hi;

    // Split requests into those at/after ptr and take the lowest set bit,
    // falling back to the lowest request overall when none are at/after ptr.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask[i] = (PW'(i) >= ptr);
        end
        hi  = req & mask;
        gnt = (|hi) ? (hi & (-hi)) : (req & (-req));
    end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: per-output round-robin lock of rx inputs onto tx outputs,
// with combinational grant relay, buffer-address and flit-data crossbars.
// Optional feature macro: SWITCH_ALLOC_BADCHNL_EN (sticky err_badchnl flag).
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int unsigned PORTS     = PORTS_DEF,
    parameter int unsigned CHNL_BITS = CHNL_BITS_DEF,
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
    parameter int unsigned FLIT_BITS = FLIT_BITS_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PORTS-1:0]             in_req,
    input  logic [PORTS*CHNL_BITS-1:0]   in_chnl,
    output logic [PORTS-1:0]             in_gnt,
    output logic [PORTS*ADDR_BITS-1:0]   in_buf_addr,
    input  logic [PORTS*FLIT_BITS-1:0]   in_buf_data,
    output logic [PORTS-1:0]             out_req,
    output logic [PORTS*CHNL_BITS-1:0]   out_chnl,
    input  logic [PORTS-1:0]             out_gnt,
    input  logic [PORTS*ADDR_BITS-1:0]   out_buf_addr,
    output logic [PORTS*FLIT_BITS-1:0]   out_buf_data,
    output logic                         err_badchnl
);

    out_state_e           state_q [PORTS];
    out_state_e           state_d [PORTS];
    logic [CHNL_BITS-1:0] owner_q [PORTS];
    logic [CHNL_BITS-1:0] owner_d [PORTS];
    logic [CHNL_BITS-1:0] ptr_q   [PORTS];
    logic [CHNL_BITS-1:0] ptr_d   [PORTS];
    logic [PORTS-1:0]     sel     [PORTS];   // sel[o][i]: output o locked to input i
    logic [PORTS-1:0]     elig    [PORTS];
    logic [PORTS-1:0]     arb_gnt [PORTS];
    logic [PORTS-1:0]     owned;

    // Crossbar: every locked output relays request/data and returns gnt/address to its owner.
    always_comb begin
        owned        = '0;
        in_gnt       = '0;
        in_buf_addr  = '0;
        out_req      = '0;
        out_chnl     = '0;
        out_buf_data = '0;
        for (int unsigned o = 0; o < PORTS; o++) begin
            sel[o] = '0;
            for (int unsigned i = 0; i < PORTS; i++) begin
                sel[o][i] = (state_q[o] == LOCKED) && (owner_q[o] == CHNL_BITS'(i));
                if (sel[o][i]) begin
                    owned[i]                                = 1'b1;
                    out_req[o]                              = in_req[i];
                    out_chnl[o*CHNL_BITS +: CHNL_BITS]      = CHNL_BITS'(i);
                    out_buf_data[o*FLIT_BITS +: FLIT_BITS]  = in_buf_data[i*FLIT_BITS +: FLIT_BITS];
                    in_gnt[i]                               = out_gnt[o];
                    in_buf_addr[i*ADDR_BITS +: ADDR_BITS]   = out_buf_addr[o*ADDR_BITS +: ADDR_BITS];
                end
            end
        end
    end

    // Eligible requesters per output: requesting it and not already holding another output.
    always_comb begin
        for (int unsigned o = 0; o < PORTS; o++) begin
            elig[o] = '0;
            for (int unsigned i = 0; i < PORTS; i++) begin
                elig[o][i] = in_req[i] & ~owned[i] &
                             (in_chnl[i*CHNL_BITS +: CHNL_BITS] == CHNL_BITS'(o));
            end
        end
    end

    for (genvar g = 0; g < PORTS; g++) begin : g_arb
        rr_arbiter #(
            .N  (PORTS),
            .PW (CHNL_BITS)
        ) u_arb (
            .req (elig[g]),
            .ptr (ptr_q[g]),
            .gnt (arb_gnt[g])
        );
    end

    // Per-output FSM: arbitrate only from IDLE, so a release always leaves one idle cycle.
    always_comb begin
        for (int unsigned o = 0; o < PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            case (state_q[o])
                IDLE: begin
                    if (|arb_gnt[o]) begin
                        state_d[o] = LOCKED;
                        for (int unsigned i = 0; i < PORTS; i++) begin
                            if (arb_gnt[o][i]) owner_d[o] = CHNL_BITS'(i);
                        end
                    end
                end
                LOCKED: begin
                    if (!out_req[o]) begin
                        state_d[o] = IDLE;
                        ptr_d[o]   = (owner_q[o] == CHNL_BITS'(PORTS - 1)) ? '0
                                                                          : owner_q[o] + CHNL_BITS'(1);
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned o = 0; o < PORTS; o++) begin
                state_q[o] <= IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end
        end else begin
            for (int unsigned o = 0; o < PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

`ifdef SWITCH_ALLOC_BADCHNL_EN
    localparam logic [CHNL_BITS:0] PORTS_W = (CHNL_BITS + 1)'(PORTS);

    logic [PORTS-1:0] chnl_bad;
    logic             err_q;
    logic             err_d;

    // Sticky flag for any request naming a non-existent output.
    always_comb begin
        for (int unsigned i = 0; i < PORTS; i++) begin
            chnl_bad[i] = in_req[i] & ({1'b0, in_chnl[i*CHNL_BITS +: CHNL_BITS]} >= PORTS_W);
        end
        err_d = err_q | (|chnl_bad);
    end

    // Error flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_badchnl = err_q;
`else
    assign err_badchnl = 1'b0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator (PORTS=5, CHNL=3, ADDR=3, FLIT=8).
module tb_switch_allocator;

    localparam int unsigned P  = 5;
    localparam int unsigned CB = 3;
    localparam int unsigned AB = 3;
    localparam int unsigned FB = 8;

`ifdef SWITCH_ALLOC_BADCHNL_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [P-1:0]    in_req, in_gnt, out_req, out_gnt;
    logic [P*CB-1:0] in_chnl, out_chnl;
    logic [P*AB-1:0] in_buf_addr, out_buf_addr;
    logic [P*FB-1:0] in_buf_data, out_buf_data;
    logic            err_badchnl;

    typedef enum {S_OREQ, S_OCHNL, S_IGNT, S_IADDR, S_ODATA, S_ERR} sig_e;
    typedef struct {
        string       name;
        sig_e        sig;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    switch_allocator #(
        .PORTS     (P),
        .CHNL_BITS (CB),
        .ADDR_BITS (AB),
        .FLIT_BITS (FB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_req       (in_req),
        .in_chnl      (in_chnl),
        .in_gnt       (in_gnt),
        .in_buf_addr  (in_buf_addr),
        .in_buf_data  (in_buf_data),
        .out_req      (out_req),
        .out_chnl     (out_chnl),
        .out_gnt      (out_gnt),
        .out_buf_addr (out_buf_addr),
        .out_buf_data (out_buf_data),
        .err_badchnl  (err_badchnl)
    );

    function automatic logic [63:0] observe(sig_e s);
        case (s)
            S_OREQ:  return 64'(out_req);
            S_OCHNL: return 64'(out_chnl);
            S_IGNT:  return 64'(in_gnt);
            S_IADDR: return 64'(in_buf_addr);
            S_ODATA: return 64'(out_buf_data);
            S_ERR:   return 64'(err_badchnl);
            default: return '0;
        endcase
    endfunction

    task automatic push(input string n, input sig_e s, input logic [63:0] v);
        exp_t e;
        e.name = n; e.sig = s; e.val = v;
        sb.push_back(e);
    endtask

    task automatic set_chnl(input int i, input logic [CB-1:0] c);
        in_chnl[i*CB +: CB] = c;
    endtask

    task automatic test_reset();
        exp_t e; logic [63:0] obs;
        repeat (2) @(negedge clk);
        push("rst_oreq", S_OREQ, 0); push("rst_ignt", S_IGNT, 0);
        push("rst_ochnl", S_OCHNL, 0); push("rst_err", S_ERR, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        reset = 1'b1;
        in_req = 5'b00001; set_chnl(0, 2); out_gnt = 5'b00100;
        @(negedge clk);
        push("rst_lock_oreq", S_OREQ, 5'b00100); push("rst_lock_ignt", S_IGNT, 5'b00001);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        @(posedge clk); #2 reset = 1'b0; #1;
        push("rst_async_oreq", S_OREQ, 0); push("rst_async_ignt", S_IGNT, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        out_gnt = '0;
        @(negedge clk); reset = 1'b1; #1;
        push("rst_nolock_oreq", S_OREQ, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        @(negedge clk);
        push("rst_relock_oreq", S_OREQ, 5'b00100);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        in_req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_path();
        exp_t e; logic [63:0] obs;
        in_req = 5'b00001; set_chnl(0, 2);
        in_buf_data[7:0] = 8'hA5; out_buf_addr[2*AB +: AB] = 3'd5;
        #1 push("sp_pre_oreq", S_OREQ, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        @(negedge clk);
        push("sp_oreq", S_OREQ, 5'b00100); push("sp_ochnl", S_OCHNL, 0);
        push("sp_odata", S_ODATA, 64'h0000_0000_00A5_0000); push("sp_iaddr", S_IADDR, 5);
        push("sp_ignt_low", S_IGNT, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        out_gnt = 5'b00100; #1;
        push("sp_ignt", S_IGNT, 5'b00001);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        in_req = '0; out_gnt = '0; #1;
        push("sp_drop_oreq", S_OREQ, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        in_buf_data = '0; out_buf_addr = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_contention();
        exp_t e; logic [63:0] obs;
        // owner order expected from ptr[0]=0 with input 1 re-requesting after its release
        int unsigned order [4] = '{1, 3, 4, 1};
        set_chnl(0, 0); set_chnl(1, 0); set_chnl(3, 0); set_chnl(4, 0);
        in_req = 5'b11010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            push($sformatf("ct_owner%0d_oreq", k), S_OREQ, 5'b00001);
            push($sformatf("ct_owner%0d_ochnl", k), S_OCHNL, 64'(order[k]));
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sig); checks++;
                if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
            end
            in_req[order[k]] = 1'b0;
            @(negedge clk);
            push($sformatf("ct_bubble%0d_oreq", k), S_OREQ, 0);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sig); checks++;
                if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
            end
            if (k == 0) in_req[1] = 1'b1;
        end
        in_req = '0;
        @(negedge clk);
    endtask

    task automatic test_parallel();
        exp_t e; logic [63:0] obs;
        in_req = 5'b00011; set_chnl(0, 1); set_chnl(1, 0);
        in_buf_data[7:0] = 8'h3C; in_buf_data[15:8] = 8'hC3;
        out_buf_addr[2:0] = 3'd6; out_buf_addr[5:3] = 3'd2;
        out_gnt = 5'b00011;
        #1 push("par_pre_oreq", S_OREQ, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        @(negedge clk);
        push("par_oreq", S_OREQ, 5'b00011); push("par_ochnl", S_OCHNL, 64'h1);
        push("par_odata", S_ODATA, 64'h3CC3); push("par_iaddr", S_IADDR, 64'h32);
        push("par_ignt", S_IGNT, 5'b00011);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        in_req = '0; out_gnt = '0; in_buf_data = '0; out_buf_addr = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_release();
        exp_t e; logic [63:0] obs;
        in_req = 5'b10100; set_chnl(2, 3); set_chnl(4, 3);
        @(negedge clk);
        push("rel_first_oreq", S_OREQ, 5'b01000); push("rel_first_ochnl", S_OCHNL, 64'h400);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        set_chnl(2, 4);
        @(negedge clk);
        push("rel_chg_oreq", S_OREQ, 5'b01000); push("rel_chg_ochnl", S_OCHNL, 64'h400);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        in_req[2] = 1'b0; #1;
        push("rel_fall_oreq", S_OREQ, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        @(negedge clk);
        push("rel_bubble_oreq", S_OREQ, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        @(negedge clk);
        push("rel_waiter_oreq", S_OREQ, 5'b01000); push("rel_waiter_ochnl", S_OCHNL, 64'h800);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        in_req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_badchnl();
        exp_t e; logic [63:0] obs;
        in_req = 5'b00011; set_chnl(0, 7); set_chnl(1, 1);
        #1 push("bad_pre_err", S_ERR, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        @(negedge clk);
        push("bad_oreq", S_OREQ, 5'b00010); push("bad_ochnl", S_OCHNL, 64'h8);
        push("bad_err", S_ERR, 64'(ERR_ON));
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        in_req = '0; set_chnl(0, 0);
        repeat (2) @(negedge clk);
        push("bad_sticky_err", S_ERR, 64'(ERR_ON)); push("bad_idle_oreq", S_OREQ, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        reset = 1'b0; #1;
        push("bad_reset_err", S_ERR, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sig); checks++;
            if (obs !== e.val) begin errors++; $display("FAIL %s: got %0h expected %0h", e.name, obs, e.val); end
        end
        @(negedge clk); reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        in_req = '0; in_chnl = '0; in_buf_data = '0;
        out_gnt = '0; out_buf_addr = '0;
        #1 reset = 1'b0;
        test_reset();
        test_single_path();
        test_contention();
        test_parallel();
        test_release();
        test_badchnl();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
